// File: rtl/mem_subword_ctrl_if.sv
// Bus bundle for mem_subword_ctrl.
//
// Carries two groups of signals:
//  - MEM-stage request/response: req_valid/req_ready handshake, request fields
//    (we, size, uns, byte address, right-justified store data) and the
//    done/rdata/misalign response.
//  - Single-port word-wide synchronous RAM: mem_en/mem_we/mem_addr/mem_wdata
//    toward the RAM, mem_rdata back. Read data arrives one cycle after a read.
//
// Modports:
//  slave  - the controller (consumes requests, drives the RAM)
//  master - the environment (pipeline MEM stage plus the RAM itself)
interface mem_subword_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_uns;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              done;
    logic [31:0]       rdata;
    logic              misalign;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
        output req_ready, done, rdata, misalign, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata, mem_rdata,
        input  req_ready, done, rdata, misalign, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_subword_ctrl.sv
// Data-memory access controller between the MIPS32 MEM stage and a
// single-port, word-wide synchronous RAM without byte enables.
//
// Loads (LB/LBU/LH/LHU/LW) read the word and extract a big-endian lane.
// SW writes directly; SB/SH do read-modify-write so only the addressed lane
// changes. Misaligned halfword/word requests are answered without touching
// the RAM.
//
// Ports:
//  CLK    - system clock, rising edge
//  reset  - asynchronous, active-high
//  bus    - mem_subword_ctrl_if.slave: request/response handshake and RAM port
//
// Response timing after the accepting edge (cycle T):
//  misaligned T+1, SW T+1, load T+2, SB/SH T+3.
module mem_subword_ctrl #(
    parameter int ADDR_W = 10
) (
    input logic             CLK,
    input logic             reset,
    mem_subword_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        RSP
    } state_t;

    state_t state_q, state_nx;

    logic              ready_q, ready_nx;
    logic              done_q, done_nx;
    logic              mis_q, mis_nx;
    logic              en_q, en_nx;
    logic              we_q, we_nx;
    logic              ld_rsp_q, ld_rsp_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [31:0]       wdata_mem_q, wdata_mem_nx;

    // Request fields captured on accept; inputs are ignored afterwards.
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;

    // Address bits above the RAM word address are deliberately ignored.
    logic addr_hi_unused;
    assign addr_hi_unused = ^bus.req_addr[31:ADDR_W+2];

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    // Big-endian lane select with sign/zero extension.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane of the old word with store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic [31:0] wdata);
        logic [31:0] m;
        m = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    m[31:24] = wdata[7:0];
                2'd1:    m[23:16] = wdata[7:0];
                2'd2:    m[15:8]  = wdata[7:0];
                default: m[7:0]   = wdata[7:0];
            endcase
        end else if (off[1]) begin
            m[15:0] = wdata[15:0];
        end else begin
            m[31:16] = wdata[15:0];
        end
        return m;
    endfunction

    // Next-state and next-output logic. Outputs are registered, so each
    // state's outputs are computed on the transition into it.
    always_comb begin
        state_nx     = state_q;
        ready_nx     = 1'b0;
        done_nx      = 1'b0;
        mis_nx       = 1'b0;
        en_nx        = 1'b0;
        we_nx        = 1'b0;
        ld_rsp_nx    = 1'b0;
        addr_nx      = addr_q;
        wdata_mem_nx = wdata_mem_q;
        case (state_q)
            IDLE: begin
                ready_nx = 1'b1;
                if (bus.req_valid) begin
                    ready_nx = 1'b0;
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_nx = RSP;
                        done_nx  = 1'b1;
                        mis_nx   = 1'b1;
                    end else if (bus.req_we && bus.req_size[1]) begin
                        state_nx     = WR;
                        en_nx        = 1'b1;
                        we_nx        = 1'b1;
                        addr_nx      = bus.req_addr[ADDR_W+1:2];
                        wdata_mem_nx = bus.req_wdata;
                        done_nx      = 1'b1;
                    end else begin
                        state_nx = RD;
                        en_nx    = 1'b1;
                        addr_nx  = bus.req_addr[ADDR_W+1:2];
                    end
                end
            end
            RD: begin
                state_nx = MRG;
                // A load completes in MRG, where the RAM word appears.
                if (!r_we) begin
                    done_nx   = 1'b1;
                    ld_rsp_nx = 1'b1;
                end
            end
            MRG: begin
                if (!r_we) begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                end else begin
                    state_nx     = WR;
                    en_nx        = 1'b1;
                    we_nx        = 1'b1;
                    wdata_mem_nx = lane_merge(bus.mem_rdata, r_size, r_off, r_wdata);
                    done_nx      = 1'b1;
                end
            end
            WR, RSP: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
            default: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            mis_q       <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            ld_rsp_q    <= 1'b0;
            addr_q      <= '0;
            wdata_mem_q <= '0;
        end else begin
            state_q     <= state_nx;
            ready_q     <= ready_nx;
            done_q      <= done_nx;
            mis_q       <= mis_nx;
            en_q        <= en_nx;
            we_q        <= we_nx;
            ld_rsp_q    <= ld_rsp_nx;
            addr_q      <= addr_nx;
            wdata_mem_q <= wdata_mem_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == IDLE && bus.req_valid) begin
            r_we    <= bus.req_we;
            r_size  <= bus.req_size;
            r_uns   <= bus.req_uns;
            r_off   <= bus.req_addr[1:0];
            r_wdata <= bus.req_wdata;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.misalign  = mis_q;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_mem_q;

    // The RAM's own output register is the pipeline stage for load data, so
    // rdata is a lane select from it, gated by the registered load-response
    // flag (zero whenever done is not a load completion).
    assign bus.rdata = ld_rsp_q ? lane_extract(bus.mem_rdata, r_size, r_off, r_uns) : 32'h0;

endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Testbench for mem_subword_ctrl: directed vector table, reset/handshake
// sequences and randomized traffic against a byte-addressed reference memory.
module tb_mem_subword_ctrl;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    mem_subword_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mem_subword_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous single-port RAM
    logic [31:0] ram [0:DEPTH-1];
    logic        ram_clear;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    always @(posedge CLK) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                wr_cnt++;
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
                rd_cnt++;
            end
        end
    end

    // Reference model: byte-addressed big-endian memory
    logic [7:0] sh [0:4*DEPTH-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd1) return addr[0];
        if (size >= 2'd2) return addr[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        int a;
        logic [31:0] v;
        a = int'(addr[11:0]);
        if (size == 2'd0) begin
            v = {24'h0, sh[a]};
            if (!uns && sh[a][7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = {16'h0, sh[a], sh[a+1]};
            if (!uns && sh[a][7]) v = v | 32'hFFFF_0000;
        end else begin
            v = {sh[a], sh[a+1], sh[a+2], sh[a+3]};
        end
        return v;
    endfunction

    function automatic void model_store(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] wd);
        int a;
        a = int'(addr[11:0]);
        if (size == 2'd0) begin
            sh[a] = wd[7:0];
        end else if (size == 2'd1) begin
            sh[a] = wd[15:8]; sh[a+1] = wd[7:0];
        end else begin
            sh[a] = wd[31:24]; sh[a+1] = wd[23:16]; sh[a+2] = wd[15:8]; sh[a+3] = wd[7:0];
        end
    endfunction

    // One access; starts and ends at a negedge.
    task automatic access(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rd, output logic got_mis,
                          output int lat, output int en_cnt, output logic done_after);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_uns   = uns;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge CLK);
        #1;
        // Inputs after accept must not matter
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_uns   = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0; en_cnt = 0; got_rd = 32'h0; got_mis = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (bus.mem_en) en_cnt++;
            if (bus.done) begin
                lat     = k;
                got_rd  = bus.rdata;
                got_mis = bus.misalign;
                break;
            end
        end
        @(negedge CLK);
        done_after = bus.done;
    endtask

    task automatic run_check(input string name, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat);
        logic [31:0] got_rd;
        logic        got_mis, done_after;
        int          lat, en_cnt, exp_en;
        access(we, size, uns, addr, wdata, got_rd, got_mis, lat, en_cnt, done_after);
        exp_en = exp_mis ? 0 : ((we && size < 2'd2) ? 2 : 1);
        chk({name, "_rdata"}, got_rd, exp_rd);
        chk({name, "_misalign"}, 32'(got_mis), 32'(exp_mis));
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_mem_en_cycles"}, 32'(en_cnt), 32'(exp_en));
        chk({name, "_done_pulse"}, 32'(done_after), 32'h0);
        if (we && !exp_mis) model_store(size, addr, wdata);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
        int          exp_lat;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [31:0] exp_rd, w;
        logic [1:0]  size;
        logic        we, uns, mis;
        logic [31:0] addr;
        int          lat, w0, r0, dcnt, bad;

        tbl[0]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0000, 32'h0000_AABB, 32'h0,          1'b0, 3};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,          32'hAABB_0000, 1'b0, 2};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h0000_CCDD, 32'h0,          1'b0, 3};
        tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,          32'hAABB_CCDD, 1'b0, 2};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0004, 32'h80FF_7F01, 32'h0,          1'b0, 1};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0004, 32'h0,          32'hFFFF_FF80, 1'b0, 2};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0004, 32'h0,          32'h0000_0080, 1'b0, 2};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0006, 32'h0,          32'h0000_7F01, 1'b0, 2};
        tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0004, 32'h0,          32'hFFFF_80FF, 1'b0, 2};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0007, 32'h0000_00EE, 32'h0,          1'b0, 3};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0,          32'h80FF_7FEE, 1'b0, 2};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,          32'h0,          1'b1, 1};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0000_1234, 32'h0,          1'b1, 1};
        tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,          32'hAABB_CCDD, 1'b0, 2};
        tbl[14] = '{1'b0, 2'd0, 1'b1, 32'h0000_0005, 32'h0,          32'h0000_00FF, 1'b0, 2};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h0000_0007, 32'h0,          32'hFFFF_FFEE, 1'b0, 2};
        tbl[16] = '{1'b0, 2'd1, 1'b1, 32'hF000_0004, 32'h0,          32'h0000_80FF, 1'b0, 2};
        tbl[17] = '{1'b0, 2'd3, 1'b0, 32'h0000_0004, 32'h0,          32'h80FF_7FEE, 1'b0, 2};

        for (int i = 0; i < 4 * DEPTH; i++) sh[i] = 8'h0;
        ram_clear     = 1'b1;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_uns   = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(negedge CLK);
        ram_clear = 1'b0;

        chk("reset_req_ready", 32'(bus.req_ready), 32'h1);
        chk("reset_ctrl", 32'({bus.done, bus.misalign, bus.mem_en, bus.mem_we}), 32'h0);
        chk("reset_rdata", bus.rdata, 32'h0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("reset_mem_wdata", bus.mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 18; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
                      tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_mis, tbl[i].exp_lat);
            if (i == 0) chk("ram0_after_sh", ram[0], 32'hAABB_0000);
            if (i == 9) chk("ram1_after_sb", ram[1], 32'h80FF_7FEE);
            if (i == 12) chk("ram0_after_misalign", ram[0], 32'hAABB_CCDD);
        end

        // Reset during the write cycle of an SH aborts the write
        run_check("sw_pre", 1'b1, 2'd2, 1'b0, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 1);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
        bus.req_uns = 1'b0; bus.req_addr = 32'h8; bus.req_wdata = 32'h0000_5566;
        @(posedge CLK);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("abort_in_write", 32'({bus.mem_en, bus.mem_we}), 32'h3);
        reset = 1'b1;
        #1;
        chk("abort_req_ready", 32'(bus.req_ready), 32'h1);
        chk("abort_ctrl", 32'({bus.done, bus.misalign, bus.mem_en, bus.mem_we}), 32'h0);
        chk("abort_rdata", bus.rdata, 32'h0);
        chk("abort_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("abort_mem_wdata", bus.mem_wdata, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        chk("abort_ram_unchanged", ram[2], 32'h1122_3344);
        @(negedge CLK);
        run_check("abort_readback", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h1122_3344, 1'b0, 2);

        // req_valid held high throughout a busy SB gives exactly one access
        w0 = wr_cnt; r0 = rd_cnt; dcnt = 0;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_uns = 1'b0; bus.req_addr = 32'hD; bus.req_wdata = 32'h0000_00A5;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus.done) begin
                dcnt++;
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        model_store(2'd0, 32'hD, 32'hA5);
        chk("held_done_count", 32'(dcnt), 32'h1);
        chk("held_write_count", 32'(wr_cnt - w0), 32'h1);
        chk("held_read_count", 32'(rd_cnt - r0), 32'h1);
        chk("held_ram", ram[3], 32'h00A5_0000);

        // Randomized traffic over a few words so loads see earlier stores
        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom);
            size = 2'($urandom);
            uns  = 1'($urandom);
            addr = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size >= 2'd2) addr[1:0] = 2'b00;
            end
            w   = $urandom;
            mis = model_mis(size, addr);
            if (mis) lat = 1;
            else if (we) lat = (size >= 2'd2) ? 1 : 3;
            else lat = 2;
            exp_rd = (!we && !mis) ? model_load(size, uns, addr) : 32'h0;
            run_check($sformatf("rnd%0d", n), we, size, uns, addr, w, exp_rd, mis, lat);
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            w = {sh[4*i], sh[4*i+1], sh[4*i+2], sh[4*i+3]};
            if (ram[i] !== w) bad++;
        end
        chk("ram_vs_model_mismatched_words", 32'(bad), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
